// File: rtl/axi_sram_if.sv
// axi_sram_if: AXI3-style bus bundle between a master and the SRAM slave.
// Signals:
//   ar*  read address channel  (master -> slave, arready back)
//   r*   read data channel     (slave -> master, rready back)
//   aw*  write address channel (master -> slave, awready back)
//   w*   write data channel    (master -> slave, wready back)
//   b*   write response        (slave -> master, bready back)
// Handshake: a beat transfers on a rising clock edge where both valid and
// ready are 1. A source holding valid=1 keeps its payload stable until that
// edge; ready may rise or fall freely and never waits on valid.
interface axi_sram_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: word-wide on-chip SRAM behind an AXI3-style slave port.
// Independent read and write FSMs, one outstanding burst per direction.
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   s_axi       axi_sram_if.slave bundle (ar/r/aw/w/b channels)
//   o_rd_state  read FSM state (0 = R_IDLE, 1 = R_DATA)
//   o_wr_state  write FSM state (0 = W_IDLE, 1 = W_DATA, 2 = W_RESP)
// Bursts: FIXED repeats the address, INCR steps one word and wraps inside the
// SRAM, WRAP/reserved burst types and out-of-range addresses give SLVERR.
module axi_sram_slave #(
  parameter int ADDR_BITS = 14,
  parameter int ID_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  axi_sram_if.slave  s_axi,
  output logic       o_rd_state,
  output logic [1:0] o_wr_state
);

  localparam int         WORDS       = 1 << ADDR_BITS;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef logic [ADDR_BITS-1:0] idx_t;

  logic [31:0] r_mem [WORDS];

  // A beat errors when the burst type is WRAP/reserved or the byte address
  // reaches beyond the SRAM.
  function automatic logic f_beat_err(input logic [31:0] addr, input logic [1:0] burst);
    return burst[1] | (|addr[31:ADDR_BITS+2]);
  endfunction

  // INCR advances only the word index, so the address wraps inside the SRAM
  // and the out-of-range bits stay as they were.
  function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [1:0] burst);
    logic [31:0] n;
    n = addr;
    if (burst == BURST_INCR) n[ADDR_BITS+1:2] = addr[ADDR_BITS+1:2] + idx_t'(1);
    return n;
  endfunction

  // ---------------------------------------------------------------- read side
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  rstate_t         r_rstate, w_rstate_nxt;
  logic [ID_W-1:0] r_rid;
  logic [31:0]     r_raddr;
  logic [7:0]      r_rlen;
  logic [1:0]      r_rburst;
  logic [7:0]      r_rcnt;
  logic [31:0]     r_rdata;
  logic [1:0]      r_rresp;
  logic            r_rlast;

  logic            w_arready, w_rvalid, w_ar_hs, w_r_hs, w_rd_err;
  logic [31:0]     w_rd_addr;
  logic [1:0]      w_rd_burst;
  logic [31:0]     w_rd_word;

  always_ff @(posedge clk) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    if (!reset) begin
      case (r_rstate)
        R_IDLE: begin
          w_arready = 1'b1;
          if (s_axi.arvalid) w_rstate_nxt = R_DATA;
        end
        R_DATA: begin
          w_rvalid = 1'b1;
          if (s_axi.rready && (r_rcnt == r_rlen)) w_rstate_nxt = R_IDLE;
        end
        default: w_rstate_nxt = R_IDLE;
      endcase
    end
  end

  assign w_ar_hs = s_axi.arvalid & w_arready;
  assign w_r_hs  = w_rvalid & s_axi.rready;

  // Address of the beat registered at this edge: the AR address for the
  // first beat, otherwise the successor of the beat being consumed.
  assign w_rd_addr  = w_ar_hs ? s_axi.araddr  : f_next_addr(r_raddr, r_rburst);
  assign w_rd_burst = w_ar_hs ? s_axi.arburst : r_rburst;
  assign w_rd_err   = f_beat_err(w_rd_addr, w_rd_burst);
  // Combinational array read; a write landing on the same edge is not seen.
  assign w_rd_word  = r_mem[w_rd_addr[ADDR_BITS+1:2]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rburst <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_rlast  <= 1'b0;
    end else if (w_ar_hs) begin
      r_rid    <= s_axi.arid;
      r_raddr  <= s_axi.araddr;
      r_rlen   <= s_axi.arlen;
      r_rburst <= s_axi.arburst;
      r_rcnt   <= '0;
      r_rdata  <= w_rd_err ? 32'h0 : w_rd_word;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      r_rlast  <= (s_axi.arlen == 8'd0);
    end else if (w_r_hs && (r_rcnt != r_rlen)) begin
      r_raddr  <= w_rd_addr;
      r_rcnt   <= r_rcnt + 8'd1;
      r_rdata  <= w_rd_err ? 32'h0 : w_rd_word;
      r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      r_rlast  <= ((r_rcnt + 8'd1) == r_rlen);
    end
  end

  assign s_axi.arready = w_arready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast & w_rvalid;

  // --------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  wstate_t         r_wstate, w_wstate_nxt;
  logic [ID_W-1:0] r_bid;
  logic [31:0]     r_waddr;
  logic [7:0]      r_wlen;
  logic [1:0]      r_wburst;
  logic [7:0]      r_wcnt;
  logic            r_werr;
  logic [1:0]      r_bresp;

  logic            w_awready, w_wready, w_bvalid, w_aw_hs, w_w_hs;
  logic            w_wr_last, w_wr_err, w_beat_bad;
  idx_t            w_wr_idx;

  always_ff @(posedge clk) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    if (!reset) begin
      case (r_wstate)
        W_IDLE: begin
          w_awready = 1'b1;
          if (s_axi.awvalid) w_wstate_nxt = W_DATA;
        end
        W_DATA: begin
          w_wready = 1'b1;
          if (s_axi.wvalid && w_wr_last) w_wstate_nxt = W_RESP;
        end
        W_RESP: begin
          w_bvalid = 1'b1;
          if (s_axi.bready) w_wstate_nxt = W_IDLE;
        end
        default: w_wstate_nxt = W_IDLE;
      endcase
    end
  end

  assign w_aw_hs   = s_axi.awvalid & w_awready;
  assign w_w_hs    = s_axi.wvalid & w_wready;
  assign w_wr_last = (r_wcnt == r_wlen);
  assign w_wr_err  = f_beat_err(r_waddr, r_wburst);
  assign w_wr_idx  = r_waddr[ADDR_BITS+1:2];
  // The beat count alone ends the burst; a disagreeing wlast only flags it.
  assign w_beat_bad = w_wr_err | (s_axi.wlast != w_wr_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wburst <= '0;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_aw_hs) begin
      r_bid    <= s_axi.awid;
      r_waddr  <= s_axi.awaddr;
      r_wlen   <= s_axi.awlen;
      r_wburst <= s_axi.awburst;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
    end else if (w_w_hs) begin
      r_werr <= r_werr | w_beat_bad;
      if (w_wr_last) begin
        r_bresp <= (r_werr | w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        r_waddr <= f_next_addr(r_waddr, r_wburst);
        r_wcnt  <= r_wcnt + 8'd1;
      end
    end
  end

  // SRAM array: no reset, byte-lane write enables.
  always_ff @(posedge clk) begin
    if (w_w_hs && !w_wr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (s_axi.wstrb[i]) r_mem[w_wr_idx][8*i +: 8] <= s_axi.wdata[8*i +: 8];
      end
    end
  end

  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_bresp;

  assign o_rd_state = r_rstate;
  assign o_wr_state = r_wstate;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: table-driven vectors, randomized bursts against an
// abstract memory model, and hand-written sequences for stalls, concurrency,
// same-word collision and reset mid-burst.
module tb_axi_sram_slave;

  localparam int         ID_W  = 4;
  localparam int         TMO   = 2000;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  // ---------------------------------------------------------- clock / reset
  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_sram_if #(.ID_W(ID_W)) bus ();
  logic       rd_state;
  logic [1:0] wr_state;

  axi_sram_slave #(.ADDR_BITS(14), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_axi      (bus),
    .o_rd_state (rd_state),
    .o_wr_state (wr_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] exp_q[$];          // {resp, data} per expected read beat
  logic [31:0] m_mem [int];       // reference memory, word index -> data

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endtask

  // SRAM is 64 KiB at byte 0; only FIXED and INCR touch memory.
  function automatic bit m_err(input logic [31:0] addr, input logic [1:0] burst);
    return (burst > 2'd1) || (addr >= 32'h0001_0000);
  endfunction

  function automatic int m_idx(input logic [31:0] addr, input logic [1:0] burst, input int b);
    if (burst == FIXED) return int'(addr >> 2);
    return int'(((addr >> 2) + b) % 16384);
  endfunction

  // ---------------------------------------------------------- driver tasks
  task automatic idle_inputs();
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = INCR;
    bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = INCR;
    bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
  endtask

  // Called on a falling edge; returns on a falling edge.
  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int stall_pct,
                          output logic [31:0] first_data, output logic [1:0] first_resp,
                          output int cycles);
    int unsigned t0;
    int          k, b;
    logic [33:0] e;
    logic [1:0]  r;
    t0 = cyc;
    first_data = '0;
    first_resp = '0;
    exp_q.delete();
    for (int i = 0; i <= int'(len); i++) begin
      r = m_err(addr, burst) ? 2'b10 : 2'b00;
      exp_q.push_back({r, (r != 2'b00) ? 32'h0 : m_mem[m_idx(addr, burst, i)]});
    end
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
    k = 0;
    while (!bus.arready && k < TMO) begin @(negedge clk); k++; end
    if (k >= TMO) tmo_fail("ar_handshake");
    @(negedge clk);
    bus.arvalid = 1'b0;
    b = 0; k = 0;
    while (b <= int'(len) && k < TMO) begin
      bus.rready = ($urandom_range(99) >= stall_pct);
      if (bus.rvalid && bus.rready) begin
        e = exp_q.pop_front();
        check("rdata", bus.rdata, e[31:0]);
        check("rresp", bus.rresp, e[33:32]);
        check("rlast", bus.rlast, b == int'(len));
        check("rid", bus.rid, id);
        if (b == 0) begin first_data = bus.rdata; first_resp = bus.rresp; end
        b++;
      end
      @(negedge clk);
      k++;
    end
    bus.rready = 1'b0;
    if (k >= TMO) tmo_fail("r_beats");
    check("r_no_extra_beat", bus.rvalid, 1'b0);
    cycles = int'(cyc - t0);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input logic [3:0] strb, input bit rand_strb,
                          input bit use_data, input logic [31:0] data, input int bad_beat,
                          input int stall_pct, output logic [1:0] resp, output int cycles);
    int unsigned t0;
    int          k, early;
    bit          err;
    logic [31:0] d, tmp;
    logic [3:0]  s;
    int          idx;
    t0 = cyc; err = 1'b0; early = 0; resp = 2'b11;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
    k = 0;
    while (!bus.awready && k < TMO) begin @(negedge clk); k++; end
    if (k >= TMO) tmo_fail("aw_handshake");
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d = use_data ? data : $urandom;
      s = rand_strb ? 4'($urandom_range(15)) : strb;
      while ($urandom_range(99) < stall_pct) begin bus.wvalid = 1'b0; @(negedge clk); end
      bus.wid = id; bus.wdata = d; bus.wstrb = s;
      bus.wlast = ((b == int'(len)) != (b == bad_beat));
      bus.wvalid = 1'b1;
      k = 0;
      while (!bus.wready && k < TMO) begin @(negedge clk); k++; end
      if (k >= TMO) begin tmo_fail("w_beat"); break; end
      if (bus.bvalid) early++;
      if (m_err(addr, burst)) err = 1'b1;
      else begin
        idx = m_idx(addr, burst, b);
        tmp = m_mem[idx];
        for (int i = 0; i < 4; i++) if (s[i]) tmp[8*i +: 8] = d[8*i +: 8];
        m_mem[idx] = tmp;
      end
      if (b == bad_beat) err = 1'b1;
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    check("b_not_early", early, 0);
    k = 0;
    while (k < TMO) begin
      bus.bready = ($urandom_range(99) >= stall_pct);
      if (bus.bvalid && bus.bready) break;
      @(negedge clk);
      k++;
    end
    if (k >= TMO) tmo_fail("b_response");
    else begin
      check("bresp", bus.bresp, err ? 2'b10 : 2'b00);
      check("bid", bus.bid, id);
      resp = bus.bresp;
    end
    @(negedge clk);
    bus.bready = 1'b0;
    check("b_dropped", bus.bvalid, 1'b0);
    cycles = int'(cyc - t0);
  endtask

  // ---------------------------------------------------------- vector table
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [3:0]  strb;
    logic [31:0] data;
    int          bad_beat;
    bit          chk_data;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [31:0] fd, old;
    logic [1:0]  fr, rsp;
    int          rc, wc, b, sel, bad;
    logic [31:0] a, r1, r2;
    logic [1:0]  bu;
    logic [7:0]  ln;
    bit          pat[6];

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_rvalid",  bus.rvalid,  1'b0);
    check("rst_rlast",   bus.rlast,   1'b0);
    check("rst_wready",  bus.wready,  1'b0);
    check("rst_bvalid",  bus.bvalid,  1'b0);
    check("rst_regs", {bus.rid, bus.rdata, bus.rresp, bus.bid, bus.bresp}, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_arready", bus.arready, 1'b1);
    check("post_rst_awready", bus.awready, 1'b1);
    check("idle_wready", bus.wready, 1'b0);

    // Fill words 0..255 (256-beat burst) and the top four words.
    wr_burst(32'h0, 8'd255, INCR, 4'd1, 4'hF, 1'b0, 1'b0, 32'h0, -1, 0, rsp, wc);
    check("len255_write_cycles", wc, 258);
    wr_burst(32'hFFF0, 8'd3, INCR, 4'd2, 4'hF, 1'b0, 1'b0, 32'h0, -1, 0, rsp, wc);
    rd_burst(32'h0, 8'd255, INCR, 4'd7, 0, fd, fr, rc);
    check("len255_read_cycles", rc, 257);

    //         wr addr           len   burst id  strb   data          bad chk exp_data      resp
    vecs[0]  = '{1, 32'h10,        8'd0, INCR,  3, 4'hF, 32'hDEADBEEF, -1, 0, 32'h0,        2'b00};
    vecs[1]  = '{0, 32'h10,        8'd0, INCR,  3, 4'h0, 32'h0,        -1, 1, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1, 32'h20,        8'd0, INCR,  5, 4'hF, 32'h0,        -1, 0, 32'h0,        2'b00};
    vecs[3]  = '{1, 32'h20,        8'd0, INCR,  5, 4'h5, 32'h11223344, -1, 0, 32'h0,        2'b00};
    vecs[4]  = '{0, 32'h20,        8'd0, INCR,  1, 4'h0, 32'h0,        -1, 1, 32'h00220044, 2'b00};
    vecs[5]  = '{0, 32'h0004_0000, 8'd0, INCR,  2, 4'h0, 32'h0,        -1, 1, 32'h0,        2'b10};
    vecs[6]  = '{1, 32'h30,        8'd1, INCR,  4, 4'hF, 32'h12345678,  0, 0, 32'h0,        2'b10};
    vecs[7]  = '{1, 32'h40,        8'd0, WRAP,  6, 4'hF, 32'h55AA55AA, -1, 0, 32'h0,        2'b10};
    vecs[8]  = '{0, 32'h40,        8'd0, INCR,  6, 4'h0, 32'h0,        -1, 0, 32'h0,        2'b00};
    vecs[9]  = '{0, 32'h40,        8'd3, WRAP,  7, 4'h0, 32'h0,        -1, 1, 32'h0,        2'b10};
    vecs[10] = '{0, 32'hFFF8,      8'd3, INCR,  8, 4'h0, 32'h0,        -1, 0, 32'h0,        2'b00};
    vecs[11] = '{1, 32'hFFFC,      8'd1, INCR,  9, 4'hF, 32'h0BADF00D, -1, 0, 32'h0,        2'b00};
    vecs[12] = '{0, 32'h8,         8'd3, FIXED, 10, 4'h0, 32'h0,       -1, 0, 32'h0,        2'b00};
    vecs[13] = '{1, 32'h50,        8'd3, FIXED, 11, 4'h3, 32'hA5A5A5A5, -1, 0, 32'h0,       2'b00};
    vecs[14] = '{0, 32'h50,        8'd0, INCR,  12, 4'h0, 32'h0,       -1, 0, 32'h0,        2'b00};
    vecs[15] = '{1, 32'h0010_0000, 8'd1, INCR,  13, 4'hF, 32'hFEEDFACE, -1, 0, 32'h0,       2'b10};
    vecs[16] = '{0, 32'h3,         8'd0, INCR,  14, 4'h0, 32'h0,       -1, 1, 32'h0BADF00D, 2'b00};
    vecs[17] = '{1, 32'h60,        8'd2, INCR,  15, 4'hF, 32'h77665544, 2, 0, 32'h0,        2'b10};
    vecs[18] = '{0, 32'h60,        8'd2, INCR,  0, 4'h0, 32'h0,        -1, 1, 32'h77665544, 2'b00};

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) begin
        wr_burst(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].id, vecs[i].strb, 1'b0, 1'b1,
                 vecs[i].data, vecs[i].bad_beat, 20, rsp, wc);
        check("tbl_bresp", rsp, vecs[i].exp_resp);
      end else begin
        rd_burst(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].id, 20, fd, fr, rc);
        check("tbl_rresp", fr, vecs[i].exp_resp);
        if (vecs[i].chk_data) check("tbl_rdata", fd, vecs[i].exp_data);
      end
    end

    // INCR read with rready pattern: stalls hold the beat, arready stays low.
    for (int j = 0; j < 4; j++)
      wr_burst(32'h20 + 32'(4*j), 8'd0, INCR, 4'd1, 4'hF, 1'b0, 1'b1, 32'(j + 1), -1, 0, rsp, wc);
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.araddr = 32'h20; bus.arlen = 8'd3; bus.arburst = INCR; bus.arid = 4'd9; bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    b = 0;
    for (int j = 0; j < 6; j++) begin
      bus.rready = pat[j];
      check("t3_arready", bus.arready, 1'b0);
      check("t3_rvalid", bus.rvalid, 1'b1);
      check("t3_rdata", bus.rdata, 32'(b + 1));
      check("t3_rlast", bus.rlast, b == 3);
      if (pat[j]) b++;
      @(negedge clk);
    end
    bus.rready = 1'b0;
    check("t3_done_rvalid", bus.rvalid, 1'b0);
    check("t3_done_arready", bus.arready, 1'b1);

    // Concurrent read and write bursts, both at full rate.
    fork
      rd_burst(32'h0, 8'd7, INCR, 4'd2, 0, fd, fr, rc);
      wr_burst(32'h100, 8'd7, INCR, 4'd3, 4'hF, 1'b0, 1'b0, 32'h0, -1, 0, rsp, wc);
    join
    check("conc_read_cycles", rc, 9);
    check("conc_write_cycles", wc, 10);

    // Same-word read and write on the same edge: read returns old data.
    old = m_mem[100];
    bus.awaddr = 32'h190; bus.awlen = 8'd0; bus.awburst = INCR; bus.awid = 4'd4; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 32'h190; bus.arlen = 8'd0; bus.arburst = INCR; bus.arid = 4'd4; bus.arvalid = 1'b1;
    check("coll_wready", bus.wready, 1'b1);
    @(negedge clk);
    bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    m_mem[100] = 32'hCAFEF00D;
    check("coll_rvalid", bus.rvalid, 1'b1);
    check("coll_old_data", bus.rdata, old);
    check("coll_bvalid", bus.bvalid, 1'b1);
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    rd_burst(32'h190, 8'd0, INCR, 4'd4, 0, fd, fr, rc);
    check("coll_new_data", fd, 32'hCAFEF00D);

    // Reset during beat 2 of a read and during a write burst.
    r1 = $urandom; r2 = $urandom;
    bus.araddr = 32'h0;   bus.arlen = 8'd7; bus.arburst = INCR; bus.arid = 4'd6; bus.arvalid = 1'b1;
    bus.awaddr = 32'h300; bus.awlen = 8'd7; bus.awburst = INCR; bus.awid = 4'd6; bus.awvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0; bus.awvalid = 1'b0;
    bus.rready = 1'b1;
    bus.wdata = r1; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    check("rst6_beat0", {bus.rvalid, bus.wready}, 2'b11);
    m_mem[192] = r1;
    @(negedge clk);
    bus.wdata = r2;
    check("rst6_beat1", {bus.rvalid, bus.wready}, 2'b11);
    m_mem[193] = r2;
    @(negedge clk);
    check("rst6_beat2_visible", bus.rvalid, 1'b1);
    reset = 1'b1; bus.rready = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("rst6_outputs_low", {bus.rvalid, bus.rlast, bus.wready, bus.bvalid, bus.arready, bus.awready}, 6'b0);
    reset = 1'b0;
    @(negedge clk);
    check("rst6_ready_back", {bus.arready, bus.awready}, 2'b11);
    check("rst6_cleared", {bus.rid, bus.rdata, bus.bid}, '0);
    bus.rready = 1'b1; bus.bready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("rst6_no_stale", {bus.rvalid, bus.bvalid, bus.wready}, 3'b0);
      @(negedge clk);
    end
    bus.rready = 1'b0; bus.bready = 1'b0;
    rd_burst(32'h300, 8'd2, INCR, 4'd5, 0, fd, fr, rc);

    // Randomized bursts against the reference model.
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(9);
      a   = ($urandom_range(200) << 2) | $urandom_range(3);
      if (sel == 0) a = a | (32'h1 << $urandom_range(31, 16));
      bu  = ($urandom_range(9) == 0) ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1));
      ln  = 8'($urandom_range(15));
      if ($urandom_range(1) == 1) begin
        bad = ($urandom_range(7) == 0) ? int'($urandom_range(int'(ln))) : -1;
        wr_burst(a, ln, bu, 4'($urandom_range(15)), 4'h0, 1'b1, 1'b0, 32'h0, bad, 30, rsp, wc);
      end else begin
        rd_burst(a, ln, bu, 4'($urandom_range(15)), 30, fd, fr, rc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
